// File: rtl/ppg_phase_scheduler.sv
// ppg_phase_scheduler
//   Run-time LED / front-end sequencer used once calibration is done. While running it
//   alternates RED and IR LED phases of PHASE_CYCLES clocks each, applies the phase's
//   DC compensation and PGA gain, ignores the ADC for SETTLE_CYCLES after each phase
//   start, then averages 2^AVG_LOG2 samples. Each RED/IR period yields one averaged
//   pair, offered to a downstream consumer over a valid/ready handshake.
//
// Ports
//   CLK, rst_n                     clock, synchronous active-low reset
//   enable, cal_valid              run request; both high to run, either low -> idle
//   ADC                            front-end sample
//   red_dc_comp/red_pga            calibrated RED settings (snapshotted at phase entry)
//   ir_dc_comp/ir_pga              calibrated IR settings (snapshotted at phase entry)
//   LED_RED, LED_IR                LED drives (never both high)
//   DC_Comp, PGA_Gain              settings applied to the front end
//   RED_ADC_Value, IR_ADC_Value    averaged pair
//   pair_valid, pair_ready         pair handshake
//   overrun                        sticky: a completed pair was dropped; cleared entering idle
module ppg_phase_scheduler #(
  parameter int unsigned PHASE_CYCLES  = 10,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cal_valid,
  input  logic [7:0] ADC,
  input  logic [6:0] red_dc_comp,
  input  logic [3:0] red_pga,
  input  logic [6:0] ir_dc_comp,
  input  logic [3:0] ir_pga,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic       pair_valid,
  input  logic       pair_ready,
  output logic       overrun
);

  localparam int unsigned NumAvg = 1 << AVG_LOG2;
  localparam int unsigned CntW   = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned AccW   = 8 + AVG_LOG2;

  localparam logic [CntW-1:0] CntAccFirst = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntAccLast  = CntW'(SETTLE_CYCLES + NumAvg - 1);
  localparam logic [CntW-1:0] CntAvg      = CntW'(SETTLE_CYCLES + NumAvg);
  localparam logic [CntW-1:0] CntLast     = CntW'(PHASE_CYCLES - 1);

  localparam logic [6:0] DcIdle  = 7'd127;
  localparam logic [3:0] PgaIdle = 4'd0;

  // The averaging slot must finish before the phase ends.
  if (SETTLE_CYCLES + NumAvg + 1 > PHASE_CYCLES) begin : g_bad_cfg
    $error("ppg_phase_scheduler: SETTLE_CYCLES + 2^AVG_LOG2 + 1 exceeds PHASE_CYCLES");
  end

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic {PhRed, PhIr} phase_e;

  state_e            state_q;
  phase_e            phase_q;
  logic [CntW-1:0]   cnt_q;
  logic [AccW-1:0]   acc_q;
  logic [7:0]        red_stage_q;

  logic              run_req;
  logic              transfer;
  logic              in_acc_win;
  logic [7:0]        avg;

  always_comb begin
    run_req    = enable && cal_valid;
    transfer   = pair_valid && pair_ready;
    in_acc_win = (cnt_q >= CntAccFirst) && (cnt_q <= CntAccLast);
    avg        = acc_q[AVG_LOG2 +: 8];  // truncating divide by 2^AVG_LOG2
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      phase_q       <= PhRed;
      cnt_q         <= '0;
      acc_q         <= '0;
      red_stage_q   <= '0;
      LED_RED       <= 1'b0;
      LED_IR        <= 1'b0;
      DC_Comp       <= DcIdle;
      PGA_Gain      <= PgaIdle;
      RED_ADC_Value <= '0;
      IR_ADC_Value  <= '0;
      pair_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // The handshake runs independently of the sequencer state; a completion below
      // may re-assert pair_valid in the same cycle.
      if (transfer) begin
        pair_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (run_req) begin
            state_q  <= StRun;
            phase_q  <= PhRed;
            cnt_q    <= '0;
            LED_RED  <= 1'b1;
            LED_IR   <= 1'b0;
            DC_Comp  <= red_dc_comp;
            PGA_Gain <= red_pga;
          end
        end

        StRun: begin
          if (!run_req) begin
            // Abort: any partial pair is discarded silently.
            state_q     <= StIdle;
            phase_q     <= PhRed;
            cnt_q       <= '0;
            acc_q       <= '0;
            red_stage_q <= '0;
            LED_RED     <= 1'b0;
            LED_IR      <= 1'b0;
            DC_Comp     <= DcIdle;
            PGA_Gain    <= PgaIdle;
            overrun     <= 1'b0;
          end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (phase_q == PhRed) begin
              phase_q  <= PhIr;
              LED_RED  <= 1'b0;
              LED_IR   <= 1'b1;
              DC_Comp  <= ir_dc_comp;
              PGA_Gain <= ir_pga;
            end else begin
              phase_q  <= PhRed;
              LED_RED  <= 1'b1;
              LED_IR   <= 1'b0;
              DC_Comp  <= red_dc_comp;
              PGA_Gain <= red_pga;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (in_acc_win) begin
              acc_q <= acc_q + AccW'(ADC);
            end
            if (cnt_q == CntAvg) begin
              acc_q <= '0;
              if (phase_q == PhRed) begin
                red_stage_q <= avg;
              end else if (!pair_valid || transfer) begin
                RED_ADC_Value <= red_stage_q;
                IR_ADC_Value  <= avg;
                pair_valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ppg_phase_scheduler.sv
module tb_ppg_phase_scheduler;

  localparam int P = 10;
  localparam int S = 2;
  localparam int L = 2;
  localparam int N = 1 << L;

  logic       CLK;
  logic       rst_n;
  logic       enable;
  logic       cal_valid;
  logic [7:0] ADC;
  logic [6:0] red_dc_comp;
  logic [3:0] red_pga;
  logic [6:0] ir_dc_comp;
  logic [3:0] ir_pga;
  logic       LED_RED;
  logic       LED_IR;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic       pair_valid;
  logic       pair_ready;
  logic       overrun;

  ppg_phase_scheduler #(
    .PHASE_CYCLES (P),
    .SETTLE_CYCLES(S),
    .AVG_LOG2     (L)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .enable       (enable),
    .cal_valid    (cal_valid),
    .ADC          (ADC),
    .red_dc_comp  (red_dc_comp),
    .red_pga      (red_pga),
    .ir_dc_comp   (ir_dc_comp),
    .ir_pga       (ir_pga),
    .LED_RED      (LED_RED),
    .LED_IR       (LED_IR),
    .DC_Comp      (DC_Comp),
    .PGA_Gain     (PGA_Gain),
    .RED_ADC_Value(RED_ADC_Value),
    .IR_ADC_Value (IR_ADC_Value),
    .pair_valid   (pair_valid),
    .pair_ready   (pair_ready),
    .overrun      (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since run start, sample sums, pending-pair flag.
  bit m_run;
  int m_t;
  int m_sum;
  int m_red_avg;
  int m_led_red, m_led_ir, m_dc, m_pga;
  int m_red_val, m_ir_val, m_pv, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_leds_idle();
    m_led_red = 0;
    m_led_ir  = 0;
    m_dc      = 127;
    m_pga     = 0;
  endtask

  task automatic model_reset();
    m_run     = 0;
    m_t       = 0;
    m_sum     = 0;
    m_red_avg = 0;
    m_red_val = 0;
    m_ir_val  = 0;
    m_pv      = 0;
    m_ovr     = 0;
    model_leds_idle();
  endtask

  task automatic model_enter_phase(input int ph);
    if (ph == 0) begin
      m_led_red = 1; m_led_ir = 0; m_dc = int'(red_dc_comp); m_pga = int'(red_pga);
    end else begin
      m_led_red = 0; m_led_ir = 1; m_dc = int'(ir_dc_comp); m_pga = int'(ir_pga);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    int cnt;
    int ph;
    int avg;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_pv != 0 && pair_ready) m_pv = 0;
    if (!m_run) begin
      if (enable && cal_valid) begin
        m_run = 1;
        m_t   = 0;
        model_enter_phase(0);
      end
    end else if (!(enable && cal_valid)) begin
      m_run     = 0;
      m_sum     = 0;
      m_red_avg = 0;
      m_ovr     = 0;
      model_leds_idle();
    end else begin
      cnt = m_t % P;
      ph  = (m_t / P) % 2;
      if (cnt >= S && cnt < S + N) m_sum += int'(ADC);
      if (cnt == S + N) begin
        avg   = m_sum / N;
        m_sum = 0;
        if (ph == 0) m_red_avg = avg;
        else if (m_pv == 0) begin
          m_red_val = m_red_avg;
          m_ir_val  = avg;
          m_pv      = 1;
        end else m_ovr = 1;
      end
      m_t++;
      if (m_t % P == 0) model_enter_phase((m_t / P) % 2);
    end
  endtask

  task automatic compare_all();
    check("led_red", LED_RED, m_led_red);
    check("led_ir", LED_IR, m_led_ir);
    check("led_excl", LED_RED & LED_IR, 0);
    check("dc_comp", DC_Comp, m_dc);
    check("pga_gain", PGA_Gain, m_pga);
    check("red_val", RED_ADC_Value, m_red_val);
    check("ir_val", IR_ADC_Value, m_ir_val);
    check("pair_valid", pair_valid, m_pv);
    check("overrun", overrun, m_ovr);
  endtask

  // One clock: inputs are already stable; sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leave the bench in RUN cycle 0 (RED, cnt 0).
  task automatic start_run();
    enable    = 1'b0;
    cal_valid = 1'b1;
    run_cycles(2);
    enable = 1'b1;
    step();
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    cal_valid   = 1'b0;
    ADC         = 8'd0;
    red_dc_comp = 7'd40;
    red_pga     = 4'd5;
    ir_dc_comp  = 7'd30;
    ir_pga      = 4'd3;
    pair_ready  = 1'b1;
    model_reset();
    run_cycles(3);
    rst_n = 1'b1;

    // Basic cadence, constant ADC.
    ADC = 8'd100;
    start_run();
    check("t2_c0_led_red", LED_RED, 1);
    check("t2_c0_dc", DC_Comp, 40);
    run_cycles(10);
    check("t2_c10_led_ir", LED_IR, 1);
    check("t2_c10_pga", PGA_Gain, 3);
    run_cycles(6);
    check("t2_c16_pv", pair_valid, 0);
    step();
    check("t2_c17_pv", pair_valid, 1);
    check("t2_c17_red", RED_ADC_Value, 100);
    check("t2_c17_ir", IR_ADC_Value, 100);

    // Reset in the middle of a run.
    run_cycles(5);
    rst_n = 1'b0;
    step();
    check("t1_pv", pair_valid, 0);
    check("t1_dc", DC_Comp, 127);
    check("t1_red_val", RED_ADC_Value, 0);
    rst_n = 1'b1;

    // Averaging with distinct samples.
    start_run();
    for (int c = 0; c < 20; c++) begin
      if (c >= S && c < S + N) ADC = 8'(10 * (c - S + 1));
      else if (c >= P) ADC = 8'd255;
      else ADC = 8'd7;
      step();
    end
    check("t3_red", RED_ADC_Value, 25);
    check("t3_ir", IR_ADC_Value, 255);

    // Back-pressure: first pair held, later ones dropped.
    pair_ready = 1'b0;
    start_run();
    for (int c = 0; c < 3 * 2 * P; c++) begin
      ADC = 8'($urandom_range(0, 255));
      step();
    end
    check("t4_ovr", overrun, 1);
    pair_ready = 1'b1;
    run_cycles(2);
    check("t4_ovr_sticky", overrun, 1);

    // Abort during IR cnt 3, then restart.
    ADC = 8'd50;
    start_run();
    run_cycles(P + 3);
    enable = 1'b0;
    step();
    check("t5_led_ir", LED_IR, 0);
    check("t5_dc", DC_Comp, 127);
    check("t5_ovr", overrun, 0);
    enable = 1'b1;
    step();
    check("t5_restart_red", LED_RED, 1);
    run_cycles(2 * P);

    // Mid-phase settings change is ignored until next RED entry.
    start_run();
    run_cycles(4);
    red_dc_comp = 7'd99;
    step();
    check("t6_dc_held", DC_Comp, 40);
    run_cycles(2 * P);

    // Randomized operation.
    for (int i = 0; i < 4000; i++) begin
      rst_n       = ($urandom_range(0, 699) != 0);
      enable      = ($urandom_range(0, 99) != 0);
      cal_valid   = ($urandom_range(0, 149) != 0);
      ADC         = 8'($urandom_range(0, 255));
      pair_ready  = ($urandom_range(0, 3) != 0);
      red_dc_comp = 7'($urandom_range(0, 127));
      red_pga     = 4'($urandom_range(0, 15));
      ir_dc_comp  = 7'($urandom_range(0, 127));
      ir_pga      = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
